// File: rtl/dmem_ws_if.sv
// Data-port bus between the core datapath and dmem_ws.
// master = core side, slave = memory side.
interface dmem_ws_if;
   logic        MStrobe;
   logic        r_w;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic [31:0] mem_out;
   logic        mem_valid;
   logic        PCReady;
   logic        mem_err;

   modport master (
      output MStrobe, r_w, mem_size, mem_addr, mem_data,
      input  mem_out, mem_valid, PCReady, mem_err
   );

   modport slave (
      input  MStrobe, r_w, mem_size, mem_addr, mem_data,
      output mem_out, mem_valid, PCReady, mem_err
   );
endinterface

// File: rtl/dmem_ws.sv
// Byte-addressed big-endian data RAM with programmable wait states.
// A request is latched in IDLE, held for WaitStates extra cycles in BUSY, then
// performed; read data and the valid/err pulses come from registers.
// Optional macro DMEM_ALIGN_CHECK_EN: flags misaligned half/word accesses with
// mem_err and suppresses their effect. Without it mem_err is constant 0.
module dmem_ws #(
   parameter int unsigned AddrSize   = 16,
   parameter int unsigned WordSize   = 8,
   parameter int unsigned WaitStates = 2
) (
   input logic      clk,
   input logic      reset_n,
   dmem_ws_if.slave bus
);

   typedef enum logic {StIdle, StBusy} state_e;

   localparam int unsigned Depth = 1 << AddrSize;

   logic [WordSize-1:0] ram [Depth];

   state_e              state;
   logic [3:0]          cnt;
   logic [AddrSize-1:0] addr;
   logic [1:0]          size;
   logic                wr;
   logic [31:0]         wdata;
   logic                ready;
   logic                valid;
   logic                err;
   logic [31:0]         out;

   logic [AddrSize-1:0] a0, a1, a2, a3;
   logic                done;
   logic                misaligned;
   logic [31:0]         rd_val;

   // Byte lanes wrap modulo the RAM size.
   assign a0 = addr;
   assign a1 = addr + AddrSize'(1);
   assign a2 = addr + AddrSize'(2);
   assign a3 = addr + AddrSize'(3);

   assign done = (state == StBusy) && (cnt == 4'd0);

`ifdef DMEM_ALIGN_CHECK_EN
   assign misaligned = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
   // No check: err can never be set, so mem_err stays tied low.
   assign misaligned = 1'b0;
`endif

   assign bus.PCReady   = ready;
   assign bus.mem_valid = valid;
   assign bus.mem_err   = err;
   assign bus.mem_out   = out;

   // Assemble big-endian read data for the latched size, zero-extended.
   always_comb begin
      rd_val = 32'h0;
      case (size)
         2'b00:   rd_val = {24'h0, ram[a0]};
         2'b01:   rd_val = {16'h0, ram[a0], ram[a1]};
         default: rd_val = {ram[a0], ram[a1], ram[a2], ram[a3]};
      endcase
   end

   // Control FSM with registered handshake outputs and read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= StIdle;
         cnt   <= 4'd0;
         addr  <= '0;
         size  <= 2'b00;
         wr    <= 1'b0;
         wdata <= 32'h0;
         ready <= 1'b1;
         valid <= 1'b0;
         err   <= 1'b0;
         out   <= 32'h0;
      end else begin
         case (state)
            StIdle: begin
               valid <= 1'b0;
               err   <= 1'b0;
               if (bus.MStrobe) begin
                  addr  <= bus.mem_addr[AddrSize-1:0];
                  size  <= bus.mem_size;
                  wr    <= bus.r_w;
                  wdata <= bus.mem_data;
                  cnt   <= 4'(WaitStates);
                  ready <= 1'b0;
                  state <= StBusy;
               end
            end
            StBusy: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  ready <= 1'b1;
                  valid <= 1'b1;
                  err   <= misaligned;
                  if (!wr && !misaligned) out <= rd_val;
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   // RAM write at the completion edge; a reset forces IDLE so no write follows.
   always_ff @(posedge clk) begin
      if (done && wr && !misaligned) begin
         case (size)
            2'b00: ram[a0] <= wdata[7:0];
            2'b01: begin
               ram[a0] <= wdata[15:8];
               ram[a1] <= wdata[7:0];
            end
            default: begin
               ram[a0] <= wdata[31:24];
               ram[a1] <= wdata[23:16];
               ram[a2] <= wdata[15:8];
               ram[a3] <= wdata[7:0];
            end
         endcase
      end
   end

endmodule

// File: doc/dmem_ws.md
Name: dmem_ws

Overview:
Parametrised successor to the Harvard data memory. Byte-addressed, big-endian RAM with programmable wait states, byte/half/word access sizes and a registered ready/valid handshake toward the datapath. It sits on the core's data port. The core stalls on PCReady low, and read data is returned from a register rather than combinationally.

Parameters:
AddrSize, 16, log2 of RAM bytes; only the low AddrSize bits of mem_addr index the RAM.
WordSize, 8, bits per RAM location; fixed at 8, since the datapath word is 4 locations.
WaitStates, 2, extra cycles per access, legal range 0..15.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
MStrobe  input  1  access request; sampled only while PCReady=1
r_w  input  1  1=write, 0=read; sampled with MStrobe
mem_size  input  2  00=byte, 01=half, 10=word, 11=treated as word
mem_addr  input  32  byte address; sampled with MStrobe
mem_data  input  32  write data, right-justified; sampled with MStrobe
mem_out  output  32  registered read data, zero-extended, right-justified
mem_valid  output  1  one-cycle pulse when an access completes
PCReady  output  1  1=idle, can accept a request; 0=busy, core must stall
mem_err  output  1  one-cycle pulse with mem_valid on a misaligned access (feature only)

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous and active-low.
- Reset values: state IDLE, PCReady=1, mem_out=0, mem_valid=0, mem_err=0, wait counter=0. RAM contents are not reset.
- States:
  - IDLE: PCReady=1.
  - BUSY: PCReady=0.
- IDLE, MStrobe=0 at the edge: stay in IDLE; mem_valid=0.
- IDLE, MStrobe=1 at edge N:
  - latch addr, size, r_w, data; load counter=WaitStates; go to BUSY.
  - PCReady=0 from edge N.
- BUSY:
  - counter>0 at the edge: decrement.
  - counter==0 at the edge: perform the access, pulse mem_valid=1, return to IDLE, PCReady=1.
- Latency: completion at edge N+1+WaitStates. WaitStates=0 gives a 1-cycle stall.
- Back-to-back: in the cycle after completion, PCReady=1, so MStrobe=1 there is accepted. Throughput is one access per 2+WaitStates cycles.
- MStrobe and all other inputs are ignored while BUSY; inputs only need to be stable at the accepting edge.
- Read, big-endian, address A:
  - byte: mem_out={24'b0, RAM[A]}.
  - half: mem_out={16'b0, RAM[A], RAM[A+1]}.
  - word: mem_out={RAM[A], RAM[A+1], RAM[A+2], RAM[A+3]}.
  - mem_out holds its value until the next read completes; writes do not change mem_out.
- Write at completion edge:
  - byte: RAM[A]=data[7:0].
  - half: RAM[A]=data[15:8], RAM[A+1]=data[7:0].
  - word: RAM[A..A+3]=data[31:24]..data[7:0].
  - Bytes outside the size are untouched.
- Address arithmetic: A+k computed modulo 2^AddrSize; accesses at the top of RAM wrap to address 0.
- Reset mid-access: the access is abandoned, no RAM write occurs, outputs return to reset values immediately.
- mem_valid and mem_err are registered single-cycle pulses, never asserted while PCReady=0.

Optional Feature:
Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - half with A[0]=1, or word with A[1:0]!=0, completes with normal latency, mem_err=1 and mem_valid=1.
  - misaligned writes leave RAM unchanged.
  - misaligned reads leave mem_out unchanged.
- Not defined:
  - no alignment check; misaligned accesses proceed with byte-granular big-endian ordering, including wrap.
  - mem_err is tied to 0.

Test Plan:
- Reset: reset_n=0 mid-BUSY write of 0xDEADBEEF to 0x10 -> PCReady=1 and mem_out=0 immediately; later word read of 0x10 returns the prior contents, not 0xDEADBEEF.
- Word write then read, WaitStates=2: write 0x11223344 to 0x20 -> PCReady low exactly 3 cycles, mem_valid pulses once. Byte reads of 0x20..0x23 return 0x11, 0x22, 0x33, 0x44.
- Sub-word writes: word 0xAABBCCDD at 0x40, then byte write 0x5A to 0x41, then half write 0x1234 to 0x42 -> word read of 0x40 returns 0xAA5A1234; half read of 0x40 returns 0x0000AA5A.
- Back-to-back and WaitStates=0: MStrobe held high for 4 reads -> requests accepted every 2nd cycle, 4 mem_valid pulses; inputs changed while BUSY are ignored.
- Wrap: AddrSize=16, word write 0x01020304 to 0xFFFE -> RAM[0xFFFE]=0x01, RAM[0xFFFF]=0x02, RAM[0x0000]=0x03, RAM[0x0001]=0x04.
- DMEM_ALIGN_CHECK_EN defined: word write to 0x102 -> mem_err and mem_valid pulse together, and RAM 0x102..0x105 is unchanged. Without the macro, the same write succeeds and mem_err stays 0.
